mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction fetch) and the
//  MEM stage (load/store). Grants one requester at a time and sequences each transfer
//  (request -> ack -> response). Drives Stall_IF / Stall_MEM into the pipeline stall logic.
//  Data accesses win over fetches; an optional guard bounds fetch starvation.
// PARAMETERS
//  ADDR_WIDTH      32  address width, both requesters and the memory port
//  DATA_WIDTH      32  data width; byte enables are DATA_WIDTH/8
//  TIMEOUT_CYCLES  15  max cycles in BUSY without Mem_ack before abort (counter 4 bits min)
//  STARVE_LIMIT     4  consecutive data grants allowed while IF_req pending (guard only)
// PORTS
//  Clk           in   1    clock
//  Reset_n       in   1    synchronous, active-low reset
//  IF_req        in   1    fetch request; held until IF_valid
//  IF_addr       in   AW   fetch address
//  IF_rdata      out  DW   fetched instruction; valid while IF_valid=1
//  IF_valid      out  1    one-cycle fetch completion pulse
//  DMEM_rd_en    in   1    load request; held until DMEM_valid
//  DMEM_wr_en    in   1    store request; held until DMEM_valid
//  DMEM_addr     in   AW   data address
//  DMEM_wdata    in   DW   store data
//  DMEM_be       in   DW/8 store byte enables
//  DMEM_rdata    out  DW   load data; valid while DMEM_valid=1 (0 for stores)
//  DMEM_valid    out  1    one-cycle data completion pulse
//  Mem_req       out  1    memory request; held until Mem_ack
//  Mem_we        out  1    1=write, 0=read
//  Mem_addr      out  AW   registered request address
//  Mem_wdata     out  DW   registered write data
//  Mem_be        out  DW/8 registered byte enables (all-ones for reads)
//  Mem_ack       in   1    memory completion, sampled only while Mem_req=1
//  Mem_rdata     in   DW   read data, valid with Mem_ack
//  Stall_IF      out  1    IF_req && !IF_valid (combinational)
//  Stall_MEM     out  1    (DMEM_rd_en||DMEM_wr_en) && !DMEM_valid (combinational)
//  Bus_err       out  1    one-cycle pulse, coincident with the aborted transfer's valid
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
//  - Reset: state IDLE, all outputs 0, counters 0. Applies mid-transfer as well:
//    Mem_req drops the next cycle and no valid is issued for the pending transfer.
//  - IDLE: data request pending -> latch DMEM_addr/wdata/be/we, go to BUSY_D. Else if
//    IF_req -> latch IF_addr, we=0, be=all-ones, go to BUSY_I. Both pending -> data wins.
//  - BUSY_x: Mem_req=1 with the latched fields stable. Mem_ack=1 at a clock edge ->
//    capture Mem_rdata, go to RESP_x. Timeout counter starts at 0 on entry and
//    increments each cycle without ack. Reaching TIMEOUT_CYCLES -> go to RESP_x with
//    rdata=0 and Bus_err=1.
//  - RESP_x: x_valid=1 for exactly one cycle, then IDLE. No grant is made in RESP, so a
//    request still held during its own valid cycle is not re-issued.
//  - Latency: request seen in IDLE at cycle N, zero-wait ack -> valid at N+2; the next
//    grant cannot occur before N+3.
//  - Mem_ack outside BUSY is ignored. IF_rdata / DMEM_rdata hold their value until the
//    next completion of the same requester.
//  - DMEM_rd_en && DMEM_wr_en both high is treated as a write.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined: a counter tracks consecutive data grants made while
//    IF_req=1. When it equals STARVE_LIMIT, the next IDLE grant goes to IF even if data is
//    pending. The counter clears on any IF grant, or on any IDLE cycle with IF_req=0.
//  Not defined: strict data priority; fetch may starve indefinitely. No counter logic.
// TESTING
//  1 IF_req=1, addr=0x100, Mem_ack one cycle after Mem_req, rdata=0x00500093 ->
//    IF_valid at N+2 with IF_rdata=0x00500093; Stall_IF=1 at N and N+1.
//  2 IF_req and DMEM_rd_en rise in the same cycle -> data serviced first (Mem_addr=DMEM_addr),
//    then fetch; DMEM_valid precedes IF_valid by 3 cycles with zero-wait memory.
//  3 Store addr=0x2000, wdata=0xDEADBEEF, be=0x3 -> Mem_we=1, Mem_be=0x3; DMEM_valid pulse
//    with DMEM_rdata=0.
//  4 Mem_ack held 0 -> Bus_err and DMEM_valid pulse together after 15 BUSY cycles;
//    Mem_req drops; rdata=0.
//  5 Reset_n=0 during BUSY_D -> Mem_req=0 next cycle, no valid, state IDLE.
//  6 GUARD_EN, STARVE_LIMIT=4, continuous loads plus IF_req -> IF granted after 4 data grants.
//    Without the macro, no IF grant occurs while loads continue.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates one single-port unified memory between instruction fetch (IF)
//   and load/store (MEM). One transfer is in flight at a time and runs
//   request -> ack -> response. Data accesses take priority over fetches.
//   A transfer that sees no Mem_ack for TIMEOUT_CYCLES busy cycles is aborted
//   with zero read data and a Bus_err pulse.
//   Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
//   consecutive data grants made while a fetch waits, the next grant goes
//   to the fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    IF_req,
  input  logic [ADDR_WIDTH-1:0]   IF_addr,
  output logic [DATA_WIDTH-1:0]   IF_rdata,
  output logic                    IF_valid,
  input  logic                    DMEM_rd_en,
  input  logic                    DMEM_wr_en,
  input  logic [ADDR_WIDTH-1:0]   DMEM_addr,
  input  logic [DATA_WIDTH-1:0]   DMEM_wdata,
  input  logic [DATA_WIDTH/8-1:0] DMEM_be,
  output logic [DATA_WIDTH-1:0]   DMEM_rdata,
  output logic                    DMEM_valid,
  output logic                    Mem_req,
  output logic                    Mem_we,
  output logic [ADDR_WIDTH-1:0]   Mem_addr,
  output logic [DATA_WIDTH-1:0]   Mem_wdata,
  output logic [DATA_WIDTH/8-1:0] Mem_be,
  input  logic                    Mem_ack,
  input  logic [DATA_WIDTH-1:0]   Mem_rdata,
  output logic                    Stall_IF,
  output logic                    Stall_MEM,
  output logic                    Bus_err
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int TMO_BITS  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_WIDTH = (TMO_BITS < 4) ? 4 : TMO_BITS;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  // Reject configurations the timeout and starvation counters cannot represent.
  if ((TIMEOUT_CYCLES < 1) || (STARVE_LIMIT < 1)) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT_CYCLES and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [TMO_WIDTH-1:0]  tmo_cnt;
  logic [TMO_WIDTH-1:0]  tmo_cnt_next;
  logic                  data_pending;
  logic                  fetch_forced;
  logic                  grant_data;
  logic                  grant_fetch;
  logic                  busy;
  logic                  busy_exit;

  // A simultaneous read and write request is a write; either one makes data pending.
  assign data_pending = DMEM_rd_en | DMEM_wr_en;

  // Stalls are combinational so the pipeline holds in the same cycle the request appears.
  assign Stall_IF  = IF_req & ~IF_valid;
  assign Stall_MEM = data_pending & ~DMEM_valid;

  assign busy      = (state == BUSY_D) || (state == BUSY_I);
  // Ack on the final allowed cycle still counts as a normal completion.
  assign busy_exit = busy && (Mem_ack || (tmo_cnt == TMO_LAST));

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_BITS  = $clog2(STARVE_LIMIT + 1);
  localparam int STARVE_WIDTH = (STARVE_BITS < 1) ? 1 : STARVE_BITS;

  logic [STARVE_WIDTH-1:0] starve_cnt;

  assign fetch_forced = IF_req && (starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));

  // Count consecutive data grants made while a fetch is waiting.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      starve_cnt <= {STARVE_WIDTH{1'b0}};
    end else if (state == IDLE) begin
      if (!IF_req || grant_fetch) begin
        starve_cnt <= {STARVE_WIDTH{1'b0}};
      end else if (grant_data) begin
        starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  // Grant decision, only taken in IDLE; data wins unless the fetch is being forced.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state == IDLE) begin
      if (data_pending && !fetch_forced) begin
        grant_data = 1'b1;
      end else if (IF_req) begin
        grant_fetch = 1'b1;
      end else begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
      end
    end else begin
      grant_data  = 1'b0;
      grant_fetch = 1'b0;
    end
  end

  // Next-state and timeout counter; no grant is made from the response states.
  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    case (state)
      IDLE: begin
        tmo_cnt_next = {TMO_WIDTH{1'b0}};
        if (grant_data) begin
          state_next = BUSY_D;
        end else if (grant_fetch) begin
          state_next = BUSY_I;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY_D, BUSY_I: begin
        if (busy_exit) begin
          state_next   = (state == BUSY_D) ? RESP_D : RESP_I;
          tmo_cnt_next = {TMO_WIDTH{1'b0}};
        end else begin
          state_next   = state;
          tmo_cnt_next = tmo_cnt + TMO_WIDTH'(1);
        end
      end
      RESP_D, RESP_I: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        tmo_cnt_next = {TMO_WIDTH{1'b0}};
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      tmo_cnt <= {TMO_WIDTH{1'b0}};
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_cnt_next;
    end
  end

  // Memory-side request fields, latched at grant and held stable for the whole transfer.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Mem_req   <= 1'b0;
      Mem_we    <= 1'b0;
      Mem_addr  <= {ADDR_WIDTH{1'b0}};
      Mem_wdata <= {DATA_WIDTH{1'b0}};
      Mem_be    <= {BE_WIDTH{1'b0}};
    end else begin
      Mem_req <= (state_next == BUSY_D) || (state_next == BUSY_I);
      if (grant_data) begin
        Mem_we    <= DMEM_wr_en;
        Mem_addr  <= DMEM_addr;
        Mem_wdata <= DMEM_wdata;
        Mem_be    <= DMEM_wr_en ? DMEM_be : {BE_WIDTH{1'b1}};
      end else if (grant_fetch) begin
        Mem_we    <= 1'b0;
        Mem_addr  <= IF_addr;
        Mem_wdata <= {DATA_WIDTH{1'b0}};
        Mem_be    <= {BE_WIDTH{1'b1}};
      end else begin
        Mem_we    <= Mem_we;
        Mem_addr  <= Mem_addr;
        Mem_wdata <= Mem_wdata;
        Mem_be    <= Mem_be;
      end
    end
  end

  // Completion pulses, error flag and read data; rdata holds until that requester's next completion.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      IF_valid   <= 1'b0;
      DMEM_valid <= 1'b0;
      Bus_err    <= 1'b0;
      IF_rdata   <= {DATA_WIDTH{1'b0}};
      DMEM_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      IF_valid   <= busy_exit && (state == BUSY_I);
      DMEM_valid <= busy_exit && (state == BUSY_D);
      Bus_err    <= busy_exit && !Mem_ack;
      if (busy_exit && (state == BUSY_I)) begin
        IF_rdata <= Mem_ack ? Mem_rdata : {DATA_WIDTH{1'b0}};
      end else begin
        IF_rdata <= IF_rdata;
      end
      if (busy_exit && (state == BUSY_D)) begin
        DMEM_rdata <= (Mem_ack && !Mem_we) ? Mem_rdata : {DATA_WIDTH{1'b0}};
      end else begin
        DMEM_rdata <= DMEM_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. The reference is a transaction-level
// model: at each free cycle it picks a winner from the pending requests, then
// derives the whole transfer timeline (busy window, valid cycle, error, data)
// from the chosen memory latency with plain arithmetic.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 15;
  localparam int SL = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          IF_req;
  logic [AW-1:0] IF_addr;
  logic [DW-1:0] IF_rdata;
  logic          IF_valid;
  logic          DMEM_rd_en;
  logic          DMEM_wr_en;
  logic [AW-1:0] DMEM_addr;
  logic [DW-1:0] DMEM_wdata;
  logic [BW-1:0] DMEM_be;
  logic [DW-1:0] DMEM_rdata;
  logic          DMEM_valid;
  logic          Mem_req;
  logic          Mem_we;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Mem_wdata;
  logic [BW-1:0] Mem_be;
  logic          Mem_ack;
  logic [DW-1:0] Mem_rdata;
  logic          Stall_IF;
  logic          Stall_MEM;
  logic          Bus_err;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .STARVE_LIMIT(SL)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_rdata(IF_rdata), .IF_valid(IF_valid),
    .DMEM_rd_en(DMEM_rd_en), .DMEM_wr_en(DMEM_wr_en), .DMEM_addr(DMEM_addr),
    .DMEM_wdata(DMEM_wdata), .DMEM_be(DMEM_be), .DMEM_rdata(DMEM_rdata),
    .DMEM_valid(DMEM_valid),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Mem_be(Mem_be), .Mem_ack(Mem_ack), .Mem_rdata(Mem_rdata),
    .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM), .Bus_err(Bus_err)
  );

  always #5 Clk = ~Clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // requester side
  bit            if_pend, d_pend, d_rd, d_wr;
  logic [AW-1:0] if_a, d_a;
  logic [DW-1:0] d_wd;
  logic [BW-1:0] d_be;

  // transfer in flight
  bit            t_act, t_isd, t_we, t_err;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_mdata;
  logic [BW-1:0] t_be;
  int            t_start, t_bend, t_lat;
  int            free_at, starve;
  logic [DW-1:0] exp_if_rd, exp_d_rd;

  // stimulus knobs and observations
  int p_if, p_d, lat_fixed;
  bit fix_lat, no_spur, rst_now;
  int first_d, first_i, d_before_i, seg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick_latency();
    int r;
    r = int'($urandom_range(9));
    if (r < 5)       return 0;
    else if (r < 7)  return int'($urandom_range(3, 1));
    else if (r == 7) return int'($urandom_range(14, 13));
    else if (r == 8) return TO;
    else             return int'($urandom_range(20, 16));
  endfunction

  function automatic bit in_busy();
    return t_act && (cyc >= t_start) && (cyc <= t_bend);
  endfunction

  task automatic step();
    bit gd, gi, ack_now, busy, vi, vd;
    int lat;
    @(posedge Clk);
    #1;
    cyc++;
    if (rst_now) begin
      if_pend = 1'b0;
      d_pend  = 1'b0;
    end else begin
      if (!if_pend && (int'($urandom_range(99)) < p_if)) begin
        if_pend = 1'b1;
        if_a    = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && (int'($urandom_range(99)) < p_d)) begin
        d_pend = 1'b1;
        case ($urandom_range(3))
          0, 1:    begin d_rd = 1'b1; d_wr = 1'b0; end
          2:       begin d_rd = 1'b0; d_wr = 1'b1; end
          default: begin d_rd = 1'b1; d_wr = 1'b1; end
        endcase
        d_a  = $urandom;
        d_wd = $urandom;
        d_be = BW'($urandom);
      end
    end
    Reset_n    = !rst_now;
    IF_req     = if_pend;
    IF_addr    = if_a;
    DMEM_rd_en = d_pend && d_rd;
    DMEM_wr_en = d_pend && d_wr;
    DMEM_addr  = d_a;
    DMEM_wdata = d_wd;
    DMEM_be    = d_be;

    // reference arbitration: one grant per free cycle, data first
    if (!rst_now && (cyc >= free_at)) begin
      if (!if_pend) starve = 0;
      gd = d_pend;
      gi = if_pend && !d_pend;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (if_pend && d_pend && (starve == SL)) begin
        gd = 1'b0;
        gi = 1'b1;
      end
`endif
      if (gd || gi) begin
        if (gi) starve = 0;
        else if (if_pend) starve++;
        lat     = fix_lat ? lat_fixed : pick_latency();
        t_act   = 1'b1;
        t_isd   = gd;
        t_we    = gd && d_wr;
        t_addr  = gd ? d_a : if_a;
        t_wdata = d_wd;
        t_be    = t_we ? d_be : {BW{1'b1}};
        t_mdata = $urandom;
        t_lat   = lat;
        t_start = cyc + 1;
        t_err   = (lat >= TO);
        t_bend  = t_err ? (t_start + TO - 1) : (t_start + lat);
        free_at = t_bend + 2;
      end
    end

    // memory responder: ack after t_lat busy cycles, stray acks outside the busy window
    ack_now = in_busy() && !t_err && (cyc == t_start + t_lat);
    if (ack_now)                   Mem_ack = 1'b1;
    else if (!in_busy() && !no_spur) Mem_ack = ($urandom_range(3) == 0);
    else                           Mem_ack = 1'b0;
    Mem_rdata = ack_now ? t_mdata : $urandom;

    @(negedge Clk);
    busy = in_busy();
    vi = t_act && !t_isd && (cyc == t_bend + 1);
    vd = t_act &&  t_isd && (cyc == t_bend + 1);
    check_eq("mem_req", 32'(Mem_req), 32'(busy));
    if (busy) begin
      check_eq("mem_addr", Mem_addr, t_addr);
      check_eq("mem_we", 32'(Mem_we), 32'(t_we));
      check_eq("mem_be", 32'(Mem_be), 32'(t_be));
      if (t_we) check_eq("mem_wdata", Mem_wdata, t_wdata);
    end
    if (vi) exp_if_rd = t_err ? {DW{1'b0}} : t_mdata;
    if (vd) exp_d_rd  = (t_err || t_we) ? {DW{1'b0}} : t_mdata;
    check_eq("if_valid", 32'(IF_valid), 32'(vi));
    check_eq("dmem_valid", 32'(DMEM_valid), 32'(vd));
    check_eq("bus_err", 32'(Bus_err), 32'((vi || vd) && t_err));
    check_eq("if_rdata", IF_rdata, exp_if_rd);
    check_eq("dmem_rdata", DMEM_rdata, exp_d_rd);
    check_eq("stall_if", 32'(Stall_IF), 32'(if_pend && !vi));
    check_eq("stall_mem", 32'(Stall_MEM), 32'(d_pend && !vd));

    if (DMEM_valid && (first_i < 0)) d_before_i++;
    if (DMEM_valid && (first_d < 0)) first_d = cyc;
    if (IF_valid && (first_i < 0))   first_i = cyc;

    if (vi) if_pend = 1'b0;
    if (vd) d_pend  = 1'b0;
    if (vi || vd) t_act = 1'b0;
    if (rst_now) begin
      t_act     = 1'b0;
      free_at   = cyc + 1;
      starve    = 0;
      exp_if_rd = {DW{1'b0}};
      exp_d_rd  = {DW{1'b0}};
    end
  endtask

  initial begin
    Reset_n = 1'b0; IF_req = 1'b0; IF_addr = '0; DMEM_rd_en = 1'b0; DMEM_wr_en = 1'b0;
    DMEM_addr = '0; DMEM_wdata = '0; DMEM_be = '0; Mem_ack = 1'b0; Mem_rdata = '0;
    if_pend = 1'b0; d_pend = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_a = '0; d_a = '0; d_wd = '0; d_be = '0;
    t_act = 1'b0; t_isd = 1'b0; t_we = 1'b0; t_err = 1'b0;
    t_addr = '0; t_wdata = '0; t_mdata = '0; t_be = '0;
    t_start = 0; t_bend = -10; t_lat = 0; free_at = 0; starve = 0;
    exp_if_rd = '0; exp_d_rd = '0;
    p_if = 40; p_d = 40; lat_fixed = 0; fix_lat = 1'b0; no_spur = 1'b0; rst_now = 1'b0;
    first_d = -1; first_i = -1; d_before_i = 0; seg = 0;

    // reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_mem_req", 32'(Mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(Mem_we), 32'd0);
    check_eq("rst_mem_addr", Mem_addr, 32'd0);
    check_eq("rst_mem_be", 32'(Mem_be), 32'd0);
    check_eq("rst_if_valid", 32'(IF_valid), 32'd0);
    check_eq("rst_dmem_valid", 32'(DMEM_valid), 32'd0);
    check_eq("rst_bus_err", 32'(Bus_err), 32'd0);
    check_eq("rst_if_rdata", IF_rdata, 32'd0);
    check_eq("rst_dmem_rdata", DMEM_rdata, 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) begin
        p_if = int'($urandom_range(90, 10));
        p_d  = int'($urandom_range(90, 10));
      end
      if ($urandom_range(299) == 0) rst_now = 1'b1;
      step();
      rst_now = 1'b0;
    end

    // drain
    p_if = 0; p_d = 0;
    repeat (20) step();

    // reset while a load is stuck in BUSY
    no_spur = 1'b1; fix_lat = 1'b1; lat_fixed = 20; p_d = 100;
    step();
    p_d = 0;
    repeat (3) step();
    check_eq("busy_before_reset", 32'(Mem_req), 32'd1);
    rst_now = 1'b1;
    step();
    rst_now = 1'b0;
    first_d = -1;
    repeat (4) step();
    check_eq("no_valid_after_reset", 32'(first_d), 32'hFFFF_FFFF);

    // fetch and load rise together, zero-wait memory
    lat_fixed = 0; first_d = -1; first_i = -1;
    p_if = 100; p_d = 100;
    step();
    seg = cyc;
    p_if = 0; p_d = 0;
    repeat (10) step();
    check_eq("data_first_latency", 32'(first_d - seg), 32'd2);
    check_eq("fetch_after_data", 32'(first_i - first_d), 32'd3);

    // continuous data requests with a waiting fetch
    rst_now = 1'b1;
    step();
    rst_now = 1'b0;
    first_d = -1; first_i = -1; d_before_i = 0;
    p_if = 100; p_d = 100;
    repeat (40) step();
`ifdef MEM_ARB_STARVE_GUARD_EN
    check_eq("guard_data_before_fetch", 32'(d_before_i), 32'(SL));
    check_eq("guard_fetch_granted", 32'(first_i >= 0), 32'd1);
`else
    check_eq("strict_no_fetch", 32'(first_i >= 0), 32'd0);
    check_eq("strict_data_continues", 32'(d_before_i >= 10), 32'd1);
`endif

    p_if = 0; p_d = 0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
